// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory bus between the MEM stage and the memory
interface mem_access_unit_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        be;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM pipeline stage: loads/stores, lane steering, alignment and bus timeout
module mem_access_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ex_regDest,
  input  logic [DATA_W-1:0]     ex_result,
  input  logic [3:0]            ex_memOp,
  input  logic [DATA_W-1:0]     ex_storeData,
  mem_access_unit_if.master     dmem,
  output logic                  stall_req,
  output logic [REG_ADDR_W-1:0] mem_regDest,
  output logic [DATA_W-1:0]     mem_result,
  output logic [1:0]            mem_excpt,
  output logic [DATA_W-1:0]     mem_badAddr
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_count, w_count_nxt;

  logic        w_is_load, w_is_store, w_is_mem, w_is_byte, w_is_half, w_misaligned;
  logic        w_req;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  // Classify the presented op by direction and access size; 9..15 fall out as NONE.
  always_comb begin
    w_is_load  = (ex_memOp >= OP_LB) && (ex_memOp <= OP_LW);
    w_is_store = (ex_memOp >= OP_SB) && (ex_memOp <= OP_SW);
    w_is_mem   = w_is_load || w_is_store;
    w_is_byte  = (ex_memOp == OP_LB) || (ex_memOp == OP_LBU) || (ex_memOp == OP_SB);
    w_is_half  = (ex_memOp == OP_LH) || (ex_memOp == OP_LHU) || (ex_memOp == OP_SH);
    w_misaligned = 1'b0;
    if (w_is_half)
      w_misaligned = ex_result[0];
    else if ((ex_memOp == OP_LW) || (ex_memOp == OP_SW))
      w_misaligned = (ex_result[1:0] != 2'b00);
  end

  // Byte enables and lane-replicated write data, sized by the access width.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_storeData;
    if (w_is_byte) begin
      w_be    = 4'b0001 << ex_result[1:0];
      w_wdata = {4{ex_storeData[7:0]}};
    end else if (w_is_half) begin
      w_be    = ex_result[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{ex_storeData[15:0]}};
    end
  end

  // Pick the addressed lane out of the returned word and extend it to 32 bits.
  always_comb begin
    case (ex_result[1:0])
      2'd0:    w_byte = dmem.rdata[7:0];
      2'd1:    w_byte = dmem.rdata[15:8];
      2'd2:    w_byte = dmem.rdata[23:16];
      default: w_byte = dmem.rdata[31:24];
    endcase
    w_half = ex_result[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (ex_memOp)
      OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_val = {24'd0, w_byte};
      OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_val = {16'd0, w_half};
      default: w_load_val = dmem.rdata;
    endcase
  end

  // State register and watchdog counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next state and stage outputs; results toward MEM_WB are zeroed whenever no writeback is due.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_req       = 1'b0;
    stall_req   = 1'b0;
    mem_regDest = ex_regDest;
    mem_result  = ex_result;
    mem_excpt   = 2'd0;
    mem_badAddr = '0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem) begin
          mem_regDest = '0;
          mem_result  = '0;
          if (w_misaligned) begin
            mem_excpt   = 2'd1;
            mem_badAddr = ex_result;
          end else begin
            w_req       = 1'b1;
            stall_req   = 1'b1;
            w_state_nxt = S_BUSY;
            w_count_nxt = 16'd0;
          end
        end
      end
      default: begin
        w_req       = 1'b1;
        mem_regDest = '0;
        mem_result  = '0;
        if (dmem.ready) begin
          w_state_nxt = S_IDLE;
          if (w_is_load) begin
            mem_regDest = ex_regDest;
            mem_result  = w_load_val;
          end
        end else if (r_count == LP_LAST) begin
          w_state_nxt = S_IDLE;
          mem_excpt   = 2'd2;
          mem_badAddr = ex_result;
        end else begin
          stall_req   = 1'b1;
          w_count_nxt = r_count + 16'd1;
        end
      end
    endcase
  end

  // Bus outputs are held at zero whenever no request is outstanding.
  always_comb begin
    dmem.req   = w_req;
    dmem.we    = w_req & w_is_store;
    dmem.addr  = w_req ? {ex_result[31:2], 2'b00} : '0;
    dmem.wdata = (w_req && w_is_store) ? w_wdata : '0;
    dmem.be    = w_req ? w_be : 4'b0000;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  ex_regDest;
  logic [31:0] ex_result;
  logic [3:0]  ex_memOp;
  logic [31:0] ex_storeData;
  logic        stall_req;
  logic [4:0]  mem_regDest;
  logic [31:0] mem_result;
  logic [1:0]  mem_excpt;
  logic [31:0] mem_badAddr;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls;
  bit seen;

  mem_access_unit_if #(.DATA_W(32)) bus ();

  mem_access_unit #(.DATA_W(32), .REG_ADDR_W(5), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_regDest   (ex_regDest),
    .ex_result    (ex_result),
    .ex_memOp     (ex_memOp),
    .ex_storeData (ex_storeData),
    .dmem         (bus),
    .stall_req    (stall_req),
    .mem_regDest  (mem_regDest),
    .mem_result   (mem_result),
    .mem_excpt    (mem_excpt),
    .mem_badAddr  (mem_badAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an op, count stall cycles, then raise ready after busy_wait BUSY cycles.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                        input logic [31:0] sd, input logic [31:0] rdata, input int busy_wait,
                        output int n_stall);
    ex_memOp = op; ex_result = addr; ex_regDest = rd; ex_storeData = sd;
    bus.ready = 1'b0;
    n_stall = 0;
    #1;
    for (int i = 0; i <= busy_wait; i++) begin
      if (stall_req) n_stall++;
      @(posedge clk); #1;
    end
    bus.ready = 1'b1; bus.rdata = rdata;
    #1;
  endtask

  task automatic end_op();
    @(posedge clk); #1;
    bus.ready = 1'b0;
    ex_memOp = 4'd0;
  endtask

  initial begin
    rst = 1'b0; ex_regDest = 5'd0; ex_result = 32'd0; ex_memOp = 4'd0; ex_storeData = 32'd0;
    bus.ready = 1'b0; bus.rdata = 32'd0;
    #3;
    check("rst_req",   {31'd0, bus.req},   32'd0);
    check("rst_we",    {31'd0, bus.we},    32'd0);
    check("rst_be",    {28'd0, bus.be},    32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_excpt", {30'd0, mem_excpt}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    ex_memOp = 4'd0; ex_regDest = 5'd7; ex_result = 32'h1234; #1;
    check("pass_rd",  {27'd0, mem_regDest}, 32'd7);
    check("pass_res", mem_result, 32'h1234);
    check("pass_req", {31'd0, bus.req}, 32'd0);
    ex_memOp = 4'd12; #1;
    check("op12_res", mem_result, 32'h1234);
    check("op12_req", {31'd0, bus.req}, 32'd0);

    run_op(4'd5, 32'h100, 5'd3, 32'd0, 32'hDEADBEEF, 2, stalls);
    check("lw_stalls", stalls, 32'd3);
    check("lw_stall0", {31'd0, stall_req}, 32'd0);
    check("lw_res",    mem_result, 32'hDEADBEEF);
    check("lw_rd",     {27'd0, mem_regDest}, 32'd3);
    check("lw_addr",   bus.addr, 32'h100);
    check("lw_be",     {28'd0, bus.be}, 32'hF);
    check("lw_we",     {31'd0, bus.we}, 32'd0);
    end_op();

    run_op(4'd1, 32'h103, 5'd4, 32'd0, 32'h80112233, 0, stalls);
    check("lb_stalls", stalls, 32'd1);
    check("lb_res",    mem_result, 32'hFFFFFF80);
    check("lb_be",     {28'd0, bus.be}, 32'h8);
    end_op();
    run_op(4'd2, 32'h103, 5'd4, 32'd0, 32'h80112233, 0, stalls);
    check("lbu_res", mem_result, 32'h00000080);
    end_op();
    run_op(4'd4, 32'h102, 5'd4, 32'd0, 32'h80112233, 0, stalls);
    check("lhu_res", mem_result, 32'h00008011);
    end_op();
    run_op(4'd3, 32'h102, 5'd4, 32'd0, 32'h80112233, 1, stalls);
    check("lh_res",    mem_result, 32'hFFFF8011);
    check("lh_stalls", stalls, 32'd2);
    end_op();

    run_op(4'd6, 32'h101, 5'd9, 32'h000000AB, 32'h0, 0, stalls);
    check("sb_wdata", bus.wdata, 32'hABABABAB);
    check("sb_be",    {28'd0, bus.be}, 32'h2);
    check("sb_we",    {31'd0, bus.we}, 32'd1);
    check("sb_addr",  bus.addr, 32'h100);
    check("sb_rd",    {27'd0, mem_regDest}, 32'd0);
    check("sb_res",   mem_result, 32'd0);
    end_op();
    run_op(4'd7, 32'h102, 5'd9, 32'h00001234, 32'h0, 0, stalls);
    check("sh_wdata", bus.wdata, 32'h12341234);
    check("sh_be",    {28'd0, bus.be}, 32'hC);
    end_op();
    run_op(4'd8, 32'h104, 5'd9, 32'hCAFEF00D, 32'h0, 0, stalls);
    check("sw_wdata", bus.wdata, 32'hCAFEF00D);
    check("sw_be",    {28'd0, bus.be}, 32'hF);
    check("sw_addr",  bus.addr, 32'h104);
    end_op();

    ex_memOp = 4'd5; ex_result = 32'h102; ex_regDest = 5'd3; #1;
    check("mis_req",   {31'd0, bus.req}, 32'd0);
    check("mis_excpt", {30'd0, mem_excpt}, 32'd1);
    check("mis_bad",   mem_badAddr, 32'h102);
    check("mis_rd",    {27'd0, mem_regDest}, 32'd0);
    check("mis_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    check("mis_idle_req", {31'd0, bus.req}, 32'd0);
    ex_memOp = 4'd0; #1;
    check("mis_clr_excpt", {30'd0, mem_excpt}, 32'd0);
    check("mis_clr_bad",   mem_badAddr, 32'd0);

    ex_memOp = 4'd5; ex_result = 32'h200; ex_regDest = 5'd6; bus.ready = 1'b0;
    stalls = 0; seen = 1'b0; #1;
    for (int i = 0; i < 20; i++) begin
      if (!stall_req) begin seen = 1'b1; break; end
      stalls++;
      @(posedge clk); #1;
    end
    check("tmo_seen",   {31'd0, seen}, 32'd1);
    check("tmo_stalls", stalls, 32'd4);
    check("tmo_excpt",  {30'd0, mem_excpt}, 32'd2);
    check("tmo_bad",    mem_badAddr, 32'h200);
    check("tmo_rd",     {27'd0, mem_regDest}, 32'd0);
    check("tmo_req_hold", {31'd0, bus.req}, 32'd1);
    @(posedge clk); #1;
    ex_memOp = 4'd0; ex_regDest = 5'd9; ex_result = 32'h55;
    bus.ready = 1'b1; bus.rdata = 32'hFFFFFFFF; #1;
    check("tmo_req_drop", {31'd0, bus.req}, 32'd0);
    check("late_rd",      {27'd0, mem_regDest}, 32'd9);
    check("late_res",     mem_result, 32'h55);
    check("late_excpt",   {30'd0, mem_excpt}, 32'd0);
    @(posedge clk); #1;
    bus.ready = 1'b0; #1;
    check("late_idle_stall", {31'd0, stall_req}, 32'd0);

    ex_memOp = 4'd5; ex_result = 32'h300; ex_regDest = 5'd2; #1;
    @(posedge clk); #1;
    check("rb_busy_req", {31'd0, bus.req}, 32'd1);
    check("rb_busy_stall", {31'd0, stall_req}, 32'd1);
    #2;
    rst = 1'b0; ex_memOp = 4'd0; #1;
    check("rb_req",   {31'd0, bus.req}, 32'd0);
    check("rb_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    ex_regDest = 5'd4; ex_result = 32'h77; bus.ready = 1'b1; bus.rdata = 32'h12345678; #1;
    check("rb_late_res", mem_result, 32'h77);
    check("rb_late_req", {31'd0, bus.req}, 32'd0);
    @(posedge clk); #1;
    bus.ready = 1'b0;
    run_op(4'd5, 32'h300, 5'd2, 32'd0, 32'h0BADF00D, 0, stalls);
    check("rb_lw_stalls", stalls, 32'd1);
    check("rb_lw_res",    mem_result, 32'h0BADF00D);
    check("rb_lw_rd",     {27'd0, mem_regDest}, 32'd2);
    end_op();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
